qpi_wb_mc_bridge: RTL and testbench
===================================

# qpi_wb_mc_bridge

Multi-channel successor to the single-requester QPI-to-Wishbone adapter. It bridges NCH cache-side QPI-style burst requesters onto one pipelined Wishbone B4 master port in front of the SDRAM controller. Each burst gets an internally incrementing address and up to MAX_OUTST outstanding read strobes. Late acknowledges after a requester aborts are drained and discarded.

## Interface
Parameters:
- NCH, 2: number of requester channels (1..8)
- AW, 23: Wishbone word-address width
- DW, 32: data width (multiple of 8)
- MAX_OUTST, 4: maximum outstanding un-acked Wishbone strobes (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- qpi_do_read  in  NCH  per-channel read-burst request, held for the whole burst
- qpi_do_write  in  NCH  per-channel write-burst request, held for the whole burst
- qpi_addr  in  NCH*AW  per-channel start word address; slice c = [c*AW +: AW]
- qpi_wdata  in  NCH*DW  per-channel write data
- qpi_rdata  out  DW  read data, shared by all channels, valid with next_word
- qpi_next_word  out  NCH  one-cycle per-channel word-done pulse
- qpi_is_idle  out  NCH  channel neither requesting nor owning the bus
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone control
- o_wb_addr  out  AW  word address
- o_wb_data  out  DW  write data
- o_wb_sel  out  DW/8  byte selects; always all ones
- i_wb_ack, i_wb_stall  in  1 each  Wishbone response and stall
- i_wb_data  in  DW  Wishbone read data

## Operation
- FSM states:
  - IDLE: arbitrate. On a grant, latch channel index, start address and direction; go to ISSUE.
  - ISSUE: issue strobes.
    - Reads: stb held while outstanding < MAX_OUTST and the granted do_read is high.
    - Writes: stb for one beat. After acceptance, stb drops until the requester has seen next_word and presented the next wdata.
    - Granted request drops: go to DRAIN.
  - DRAIN: stb=0, cyc=1 until outstanding == 0, then go to IDLE.
- A request with both do_read and do_write high is treated as a write.
- Address advances by 1 per accepted strobe (stb & !stall) and wraps modulo 2^AW.
- Outstanding counter (clog2(MAX_OUTST+1) bits):
  - +1 on accepted strobe, −1 on ack; both in the same cycle leaves it unchanged.
  - An ack with outstanding == 0 is ignored and the counter does not underflow.
- Read next_word: registered copy of ack, gated by the granted do_read still high. Acks in DRAIN produce no pulse; their data is discarded.
- Write next_word: pulses the cycle after the beat's strobe is accepted. Write acks only decrement the counter.
- qpi_is_idle[c] = !(do_read[c] | do_write[c]) and not (channel c granted and state != IDLE).
- A channel dropping its request while not granted is simply never served.
- Reset mid-burst: FSM to IDLE, counter cleared, cyc/stb drop in the same clock edge. In-flight acks after reset are ignored.

## Timing
- Reset values: o_wb_cyc/stb/we=0, o_wb_addr=0, o_wb_data=0, qpi_next_word=0, qpi_rdata=0. qpi_is_idle is combinational and reads 1 for every non-requesting channel.
- Request sampled at edge t: cyc and stb high from cycle t+1.
- Read stream with stall=0 and single-cycle ack: one word per cycle. next_word and rdata arrive one cycle after ack.
- Write beat period is 3 cycles minimum:
  - Beat accepted in cycle t.
  - next_word high in cycle t+1.
  - New wdata/do_write sampled at t+2.
  - Next stb in cycle t+3.
- One extra read strobe may be issued in the cycle after do_read drops. It is drained normally.
- A new grant is possible one cycle after DRAIN reaches outstanding == 0, i.e. cyc drops for at least one cycle between bursts.

## Configuration
- QPI_WB_MC_BRIDGE_RR_EN defined: round-robin arbitration. Priority pointer moves to the granted channel + 1 modulo NCH on each grant.
- Undefined: fixed priority, lowest channel index wins.

## Structure
- Package qpi_wb_pkg: FSM state enum (ST_IDLE, ST_ISSUE, ST_DRAIN) and counter-width helper function.
- Sub-module qpi_wb_arb: NCH-wide request-to-one-hot/index arbiter, containing the macro-selected policy.

## Test plan
- Ch0 reads 4 words from 0x000100, stall=0, 1-cycle ack: o_wb_addr 0x100..0x103. next_word pulses on 4 consecutive cycles with matching rdata. cyc drops after the last ack.
- Ch1 writes 0xA5A5_0001, 0xA5A5_0002 at 0x7FFFFF: addresses 0x7FFFFF then 0x000000 (wrap). Beats are ≥3 cycles apart, we=1, sel=0xF.
- Slave stalls 3 cycles, then acks with 5-cycle latency, MAX_OUTST=4: never more than 4 strobes un-acked. Counter returns to 0.
- Ch0 drops do_read after 2 words with 3 strobes outstanding: no further next_word. cyc stays high until the remaining acks arrive, then IDLE.
- Ch0 and ch1 request simultaneously, back-to-back: with RR_EN the grants alternate 0,1,0. Without it, ch0 is always granted first.
- rst asserted mid-read burst: the next cycle has cyc=0, stb=0, next_word=0. A late ack produces no pulse.

Source files
------------

// File: rtl/qpi_wb_pkg.sv
// Shared types and sizing helpers for the multi-channel QPI-to-Wishbone bridge.
package qpi_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Bits needed to count 0..n inclusive (never less than one).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n items (never less than one).
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qpi_wb_arb.sv
// Request arbiter: fixed lowest-index priority, or round-robin when
// QPI_WB_MC_BRIDGE_RR_EN is defined.
module qpi_wb_arb
  import qpi_wb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = idx_width(NCH)
) (
`ifdef QPI_WB_MC_BRIDGE_RR_EN
  input  logic           clk,
  input  logic           rst,
  input  logic           take_i,
`endif
  input  logic [NCH-1:0] req_i,
  output logic           gnt_valid_o,
  output logic [IW-1:0]  gnt_idx_o,
  output logic [NCH-1:0] gnt_oh_o
);

`ifdef QPI_WB_MC_BRIDGE_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Scan downward from ptr+NCH-1 to ptr so the channel nearest the pointer wins.
  always_comb begin
    int c;
    c           = 0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      c = int'(ptr_q) + k;
      if (c >= NCH) c = c - NCH;
      if (req_i[c]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IW'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take_i && gnt_valid_o) begin
      ptr_d = (int'(gnt_idx_o) == NCH - 1) ? '0 : gnt_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (req_i[c]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IW'(c);
      end
    end
  end
`endif

  assign gnt_oh_o = gnt_valid_o ? (NCH'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/qpi_wb_mc_bridge.sv
// NCH QPI-style burst requesters onto one pipelined Wishbone B4 master.
// Define QPI_WB_MC_BRIDGE_RR_EN for round-robin arbitration (default: fixed priority).
module qpi_wb_mc_bridge
  import qpi_wb_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int AW        = 23,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    qpi_do_read,
  input  logic [NCH-1:0]    qpi_do_write,
  input  logic [NCH*AW-1:0] qpi_addr,
  input  logic [NCH*DW-1:0] qpi_wdata,
  output logic [DW-1:0]     qpi_rdata,
  output logic [NCH-1:0]    qpi_next_word,
  output logic [NCH-1:0]    qpi_is_idle,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DW-1:0]     o_wb_data,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic [DW-1:0]     i_wb_data
);

  localparam int CW = cnt_width(MAX_OUTST);
  localparam int IW = idx_width(NCH);

  state_e        state_q, state_d;
  logic [IW-1:0] chan_q, chan_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rdata_q;
  logic [CW-1:0] outst_q, outst_d;
  logic [1:0]    gap_q, gap_d;
  logic [NCH-1:0] nw_q;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;

  logic           gnt_valid;
  logic [IW-1:0]  gnt_idx;
  logic [NCH-1:0] gnt_oh;
  logic [NCH-1:0] chan_oh;
  logic           req_rd, req_wr, req_act;
  logic           accept, ack_ok, cap_ok;
  logic           rd_pulse, wr_pulse;
  logic [AW-1:0]  gnt_addr;
  logic [DW-1:0]  gnt_wdata, cur_wdata;

  qpi_wb_arb #(.NCH(NCH), .IW(IW)) u_arb (
`ifdef QPI_WB_MC_BRIDGE_RR_EN
    .clk         (clk),
    .rst         (rst),
    .take_i      (state_q == ST_IDLE),
`endif
    .req_i       (qpi_do_read | qpi_do_write),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .gnt_oh_o    (gnt_oh)
  );

  assign gnt_addr  = qpi_addr[int'(gnt_idx)*AW +: AW];
  assign gnt_wdata = qpi_wdata[int'(gnt_idx)*DW +: DW];
  assign cur_wdata = qpi_wdata[int'(chan_q)*DW +: DW];
  assign chan_oh   = NCH'(1) << chan_q;

  assign req_rd  = qpi_do_read[chan_q];
  assign req_wr  = qpi_do_write[chan_q];
  assign req_act = we_q ? req_wr : req_rd;

  assign accept = stb_q & ~i_wb_stall;
  // Acks with nothing outstanding (e.g. stragglers from before a reset) are dropped.
  assign ack_ok = i_wb_ack & (outst_q != '0);

  always_comb begin
    unique case ({accept, ack_ok})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  assign cap_ok = (outst_d < CW'(MAX_OUTST));

  assign rd_pulse = ack_ok & ~we_q & req_rd & (state_q == ST_ISSUE);
  assign wr_pulse = accept & we_q;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    gap_d   = gap_q;

    if (accept) addr_d = addr_q + AW'(1);

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_ISSUE;
          chan_d  = gnt_idx;
          addr_d  = gnt_addr;
          we_d    = |(qpi_do_write & gnt_oh);
          data_d  = gnt_wdata;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          gap_d   = 2'd0;
        end
      end
      ST_ISSUE: begin
        if (!req_act) begin
          state_d = ST_DRAIN;
          stb_d   = 1'b0;
        end else if (!we_q) begin
          stb_d = cap_ok;
        end else if (stb_q) begin
          // Write beat: one strobe, then wait for the requester to refresh wdata.
          if (accept) begin
            stb_d = 1'b0;
            gap_d = 2'd2;
          end
        end else if (gap_q == 2'd2) begin
          gap_d = 2'd1;
        end else if (cap_ok) begin
          stb_d  = 1'b1;
          data_d = cur_wdata;
          gap_d  = 2'd0;
        end
      end
      ST_DRAIN: begin
        stb_d = 1'b0;
        if (outst_d == '0) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      gap_q   <= 2'd0;
      outst_q <= '0;
      nw_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      gap_q   <= gap_d;
      outst_q <= outst_d;
      nw_q    <= (rd_pulse | wr_pulse) ? chan_oh : '0;
      rdata_q <= rd_pulse ? i_wb_data : rdata_q;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_idle
    assign qpi_is_idle[gi] = ~(qpi_do_read[gi] | qpi_do_write[gi]) &
                             ~((chan_q == IW'(gi)) & (state_q != ST_IDLE));
  end

  assign qpi_rdata     = rdata_q;
  assign qpi_next_word = nw_q;
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = stb_q;
  assign o_wb_we       = we_q & cyc_q;
  assign o_wb_addr     = addr_q;
  assign o_wb_data     = data_q;
  assign o_wb_sel      = '1;

endmodule

// File: tb/tb_qpi_wb_mc_bridge.sv
// Directed bench for qpi_wb_mc_bridge with a latency/stall-programmable Wishbone slave.
module tb_qpi_wb_mc_bridge;

  localparam int NCH = 2;
  localparam int AW  = 23;
  localparam int DW  = 32;
  localparam int MO  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    qpi_do_read = '0;
  logic [NCH-1:0]    qpi_do_write = '0;
  logic [NCH*AW-1:0] qpi_addr = '0;
  logic [NCH*DW-1:0] qpi_wdata = '0;
  logic [DW-1:0]     qpi_rdata;
  logic [NCH-1:0]    qpi_next_word;
  logic [NCH-1:0]    qpi_is_idle;
  logic              o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]     o_wb_addr;
  logic [DW-1:0]     o_wb_data;
  logic [DW/8-1:0]   o_wb_sel;
  logic              i_wb_ack = 1'b0;
  logic              i_wb_stall = 1'b0;
  logic [DW-1:0]     i_wb_data = '0;

  qpi_wb_mc_bridge #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_OUTST(MO)) dut (
    .clk           (clk),
    .rst           (rst),
    .qpi_do_read   (qpi_do_read),
    .qpi_do_write  (qpi_do_write),
    .qpi_addr      (qpi_addr),
    .qpi_wdata     (qpi_wdata),
    .qpi_rdata     (qpi_rdata),
    .qpi_next_word (qpi_next_word),
    .qpi_is_idle   (qpi_is_idle),
    .o_wb_cyc      (o_wb_cyc),
    .o_wb_stb      (o_wb_stb),
    .o_wb_we       (o_wb_we),
    .o_wb_addr     (o_wb_addr),
    .o_wb_data     (o_wb_data),
    .o_wb_sel      (o_wb_sel),
    .i_wb_ack      (i_wb_ack),
    .i_wb_stall    (i_wb_stall),
    .i_wb_data     (i_wb_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Slave model and bus/requester monitor state.
  int cyc_n = 0;
  int lat = 1;
  int stall_left = 0;
  int due_q[$];
  logic [AW-1:0] padr_q[$];
  logic [AW-1:0] acc_addr[$];
  logic [DW-1:0] acc_data[$];
  logic          acc_we[$];
  logic [3:0]    acc_sel[$];
  int            acc_cyc[$];
  logic [AW-1:0] burst_start[$];
  logic [DW-1:0] nw_data[$];
  int            nw_cyc[$];
  int nw_cnt[NCH];
  int tot_acc = 0, tot_ack = 0, max_out = 0;
  int ack_last = 0, cyc_fall = 0;
  logic prev_cyc = 1'b0;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {9'd0, a};
  endfunction

  always @(negedge clk) begin
    cyc_n++;
    i_wb_stall = o_wb_cyc && (stall_left > 0);
    if (i_wb_stall) stall_left--;
    i_wb_ack = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc_n) begin
      i_wb_ack  = 1'b1;
      i_wb_data = rd_val(padr_q[0]);
      void'(due_q.pop_front());
      void'(padr_q.pop_front());
      tot_ack++;
      ack_last = cyc_n;
    end
    if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
      due_q.push_back(cyc_n + lat);
      padr_q.push_back(o_wb_addr);
      acc_addr.push_back(o_wb_addr);
      acc_data.push_back(o_wb_data);
      acc_we.push_back(o_wb_we);
      acc_sel.push_back(o_wb_sel);
      acc_cyc.push_back(cyc_n);
      tot_acc++;
    end
    if (o_wb_cyc && !prev_cyc) burst_start.push_back(o_wb_addr);
    if (!o_wb_cyc && prev_cyc) cyc_fall = cyc_n;
    prev_cyc = o_wb_cyc;
    if (tot_acc - tot_ack > max_out) max_out = tot_acc - tot_ack;
    for (int c = 0; c < NCH; c++) if (qpi_next_word[c]) nw_cnt[c]++;
    if (qpi_next_word != '0) begin
      nw_data.push_back(qpi_rdata);
      nw_cyc.push_back(cyc_n);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_nw(input int ch, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (qpi_next_word[ch]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!o_wb_cyc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_data.delete(); acc_we.delete();
    acc_sel.delete(); acc_cyc.delete(); burst_start.delete();
    nw_data.delete(); nw_cyc.delete();
    for (int c = 0; c < NCH; c++) nw_cnt[c] = 0;
    max_out = tot_acc - tot_ack;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c;
    logic [AW-1:0] exp_start[3];

    // Reset values
    tick(3);
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_we", o_wb_we, 0);
    chk("rst_addr", o_wb_addr, 0);
    chk("rst_data", o_wb_data, 0);
    chk("rst_next_word", qpi_next_word, 0);
    chk("rst_rdata", qpi_rdata, 0);
    chk("rst_is_idle", qpi_is_idle, 2'b11);
    chk("rst_sel", o_wb_sel, 4'hF);
    rst = 1'b0;
    tick(2);

    // A: ch0 reads 4 words from 0x100, no stall, 1-cycle ack
    clear_logs();
    lat = 1;
    qpi_addr[0 +: AW] = 23'h000100;
    qpi_do_read[0] = 1'b1;
    for (int w = 0; w < 4; w++) begin
      wait_nw(0, 20, ok);
      chk("rdA_pulse_seen", ok, 1);
      if (w == 0) chk("rdA_is_idle", qpi_is_idle, 2'b10);
    end
    qpi_do_read[0] = 1'b0;
    wait_idle(30, ok);
    chk("rdA_idle_reached", ok, 1);
    tick(3);
    for (int i = 0; i < 4; i++) chk("rdA_addr", acc_addr[i], 23'h000100 + i);
    chk("rdA_addr_stream", acc_cyc[3] - acc_cyc[0], 3);
    chk("rdA_nw_count", nw_cnt[0], 4);
    for (int i = 0; i < 4; i++) chk("rdA_rdata", nw_data[i], rd_val(23'h000100 + i));
    chk("rdA_nw_stream", nw_cyc[3] - nw_cyc[0], 3);
    chk("rdA_first_latency", nw_cyc[0] - acc_cyc[0], 2);
    chk("rdA_cyc_fall", cyc_fall, ack_last + 1);
    chk("rdA_drained", tot_acc - tot_ack, 0);
    chk("rdA_is_idle_end", qpi_is_idle, 2'b11);

    // B: ch1 writes two beats at 0x7FFFFF, address wraps to 0
    clear_logs();
    qpi_addr[AW +: AW] = 23'h7FFFFF;
    qpi_wdata[DW +: DW] = 32'hA5A5_0001;
    qpi_do_write[1] = 1'b1;
    wait_nw(1, 20, ok);
    chk("wrB_beat1_done", ok, 1);
    qpi_wdata[DW +: DW] = 32'hA5A5_0002;
    wait_nw(1, 20, ok);
    chk("wrB_beat2_done", ok, 1);
    qpi_do_write[1] = 1'b0;
    wait_idle(30, ok);
    chk("wrB_idle_reached", ok, 1);
    tick(3);
    chk("wrB_strobes", acc_addr.size(), 2);
    chk("wrB_addr0", acc_addr[0], 23'h7FFFFF);
    chk("wrB_addr1_wrap", acc_addr[1], 23'h000000);
    chk("wrB_data0", acc_data[0], 32'hA5A5_0001);
    chk("wrB_data1", acc_data[1], 32'hA5A5_0002);
    chk("wrB_we", {acc_we[0], acc_we[1]}, 2'b11);
    chk("wrB_sel", acc_sel[1], 4'hF);
    chk("wrB_beat_gap_ge3", (acc_cyc[1] - acc_cyc[0]) >= 3, 1);
    chk("wrB_nw_latency", nw_cyc[0] - acc_cyc[0], 1);
    chk("wrB_nw_ch1", nw_cnt[1], 2);
    chk("wrB_nw_ch0", nw_cnt[0], 0);
    chk("wrB_rdata_kept", qpi_rdata, rd_val(23'h000103));

    // E: both channels request back to back
    clear_logs();
    qpi_addr[0 +: AW]  = 23'h001000;
    qpi_addr[AW +: AW] = 23'h002000;
    qpi_do_read = 2'b11;
    for (int g = 0; g < 3; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (qpi_next_word != '0) begin
          ok = 1'b1;
          break;
        end
      end
      chk("arbE_grant_served", ok, 1);
      c = qpi_next_word[1] ? 1 : 0;
      if (g == 2) begin
        qpi_do_read = 2'b00;
      end else begin
        qpi_do_read[c] = 1'b0;
        @(negedge clk);
        qpi_do_read[c] = 1'b1;
      end
    end
    wait_idle(30, ok);
    chk("arbE_idle_reached", ok, 1);
    tick(3);
`ifdef QPI_WB_MC_BRIDGE_RR_EN
    exp_start[0] = 23'h001000; exp_start[1] = 23'h002000; exp_start[2] = 23'h001000;
`else
    exp_start[0] = 23'h001000; exp_start[1] = 23'h001000; exp_start[2] = 23'h001000;
`endif
    chk("arbE_bursts", burst_start.size(), 3);
    for (int i = 0; i < 3; i++) chk("arbE_grant_addr", burst_start[i], exp_start[i]);

    // C: 3 stall cycles then 5-cycle ack latency; outstanding capped at MAX_OUTST
    clear_logs();
    lat = 5;
    stall_left = 3;
    qpi_addr[0 +: AW] = 23'h000200;
    qpi_do_read[0] = 1'b1;
    for (int w = 0; w < 6; w++) begin
      wait_nw(0, 40, ok);
      chk("stC_pulse_seen", ok, 1);
    end
    qpi_do_read[0] = 1'b0;
    wait_idle(40, ok);
    chk("stC_idle_reached", ok, 1);
    tick(3);
    chk("stC_max_outst", max_out, 4);
    chk("stC_nw_count", nw_cnt[0], 6);
    chk("stC_addr0_held", acc_addr[0], 23'h000200);
    chk("stC_addr4", acc_addr[4], 23'h000204);
    chk("stC_rdata0", nw_data[0], rd_val(23'h000200));
    chk("stC_rdata5", nw_data[5], rd_val(23'h000205));
    chk("stC_drained", tot_acc - tot_ack, 0);

    // D: drop after 2 words with 3 reads in flight
    clear_logs();
    lat = 3;
    qpi_addr[0 +: AW] = 23'h000300;
    qpi_do_read[0] = 1'b1;
    for (int w = 0; w < 2; w++) begin
      wait_nw(0, 30, ok);
      chk("drD_pulse_seen", ok, 1);
    end
    qpi_do_read[0] = 1'b0;
    @(negedge clk);
    chk("drD_is_idle_drain", qpi_is_idle, 2'b10);
    chk("drD_stb_drain", o_wb_stb, 0);
    chk("drD_cyc_drain", o_wb_cyc, 1);
    wait_idle(30, ok);
    chk("drD_idle_reached", ok, 1);
    tick(3);
    chk("drD_nw_count", nw_cnt[0], 2);
    chk("drD_cyc_fall", cyc_fall, ack_last + 1);
    chk("drD_rdata_last", qpi_rdata, rd_val(23'h000301));
    chk("drD_drained", tot_acc - tot_ack, 0);

    // F: reset in the middle of a read burst, late acks ignored
    clear_logs();
    lat = 3;
    qpi_addr[0 +: AW] = 23'h000400;
    qpi_do_read[0] = 1'b1;
    tick(2);
    rst = 1'b1;
    qpi_do_read[0] = 1'b0;
    @(negedge clk);
    chk("rstF_cyc", o_wb_cyc, 0);
    chk("rstF_stb", o_wb_stb, 0);
    chk("rstF_next_word", qpi_next_word, 0);
    chk("rstF_rdata", qpi_rdata, 0);
    rst = 1'b0;
    tick(8);
    chk("rstF_late_acks_seen", tot_acc - tot_ack, 0);
    chk("rstF_no_pulse", nw_cnt[0], 0);
    chk("rstF_no_regrant", burst_start.size(), 1);
    chk("rstF_cyc_low", o_wb_cyc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
